// File: rtl/sc_useq_pkg.sv
// Shared definitions for the micro-sequencer: next-field opcodes, FSM states,
// default field widths and bit offsets of the microword, and the NOP word.
package sc_useq_pkg;

  // Default field widths
  localparam int DEC_W     = 3;
  localparam int MUX_W     = 6;
  localparam int ALU_W     = 4;
  localparam int SHIFT_W   = 2;
  localparam int UPC_W     = 4;
  localparam int LOOPCNT_W = 5;
  localparam int NEXT_W    = 3;
  localparam int UWORD_W   = DEC_W + 2*MUX_W + ALU_W + 1 + SHIFT_W + NEXT_W + UPC_W;

  // Microword layout (LSB upward): target, next, shSel, shLoad_n, alu, muxB, muxA, dec
  localparam int OFF_TARGET = 0;
  localparam int OFF_NEXT   = OFF_TARGET + UPC_W;
  localparam int OFF_SHSEL  = OFF_NEXT + NEXT_W;
  localparam int OFF_SHLOAD = OFF_SHSEL + SHIFT_W;
  localparam int OFF_ALU    = OFF_SHLOAD + 1;
  localparam int OFF_MUXB   = OFF_ALU + ALU_W;
  localparam int OFF_MUXA   = OFF_MUXB + MUX_W;
  localparam int OFF_DEC    = OFF_MUXA + MUX_W;

  // Next-address opcodes; the spare code behaves as HALT
  typedef enum logic [2:0] {
    NX_SEQ  = 3'd0,
    NX_JMP  = 3'd1,
    NX_BRZ  = 3'd2,
    NX_BRN  = 3'd3,
    NX_BRC  = 3'd4,
    NX_LOOP = 3'd5,
    NX_HALT = 3'd6,
    NX_RSVD = 3'd7
  } nextOp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seqState_t;

  // NOP control word: nothing written, shifter load deasserted (active low)
  localparam logic NOP_SHLOAD_N = 1'b1;
  localparam logic [UWORD_W-1:0] NOP_WORD = UWORD_W'(1) << OFF_SHLOAD;

endpackage

// File: rtl/sc_useq_store.sv
// Micro-program store: 2^ADDR_W words, synchronous write, combinational read,
// asynchronous clear of every word to zero (SEQ / all-zero fields).
module sc_useq_store #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 29
)(
  input  logic              clk,
  input  logic              rstN,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : gWord
      // One register per word, written only when addressed
      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
          mem[g] <= '0;
        else if (wrEn && (wrAddr == ADDR_W'(g)))
          mem[g] <= wrData;
      end
    end
  endgenerate

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/sc_useq_controller.sv
// Microprogrammed sequencer driving the uDataPath control inputs.
// Optional build macro SC_USEQ_WATCHDOG_EN adds an 8-bit RUN-cycle watchdog
// that aborts a routine after 255 RUN cycles and flags SC_USEQ_Timeout_Out.
module sc_useq_controller
  import sc_useq_pkg::*;
#(
  parameter int DATAWIDTH_DECODER_SELECTION    = DEC_W,
  parameter int DATAWIDTH_MUX_SELECTION        = MUX_W,
  parameter int DATAWIDTH_ALU_SELECTION        = ALU_W,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = SHIFT_W,
  parameter int UPC_WIDTH                      = UPC_W,
  parameter int LOOPCNT_WIDTH                  = LOOPCNT_W,
  localparam int UWORD_WIDTH = DATAWIDTH_DECODER_SELECTION + 2*DATAWIDTH_MUX_SELECTION +
                               DATAWIDTH_ALU_SELECTION + 1 + DATAWIDTH_REGSHIFTER_SELECTION +
                               NEXT_W + UPC_WIDTH
)(
  input  logic                                      SC_USEQ_CLOCK_50,
  input  logic                                      SC_USEQ_Reset_InLow,
  input  logic                                      SC_USEQ_Start_In,
  input  logic [UPC_WIDTH-1:0]                      SC_USEQ_StartAddr_In,
  input  logic [LOOPCNT_WIDTH-1:0]                  SC_USEQ_LoopCount_In,
  input  logic                                      SC_USEQ_ProgWrite_In,
  input  logic [UPC_WIDTH-1:0]                      SC_USEQ_ProgAddr_In,
  input  logic [UWORD_WIDTH-1:0]                    SC_USEQ_ProgData_In,
  input  logic                                      SC_USEQ_Overflow_InLow,
  input  logic                                      SC_USEQ_Carry_InLow,
  input  logic                                      SC_USEQ_Negative_InLow,
  input  logic                                      SC_USEQ_Zero_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_USEQ_DecoderSelectionWrite_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_USEQ_MUXSelectionBUSA_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_USEQ_MUXSelectionBUSB_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_USEQ_ALUSelection_Out,
  output logic                                      SC_USEQ_RegSHIFTERLoad_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_USEQ_RegSHIFTERShiftSelection_OutLow,
`ifdef SC_USEQ_WATCHDOG_EN
  output logic                                      SC_USEQ_Timeout_Out,
`endif
  output logic                                      SC_USEQ_Busy_Out,
  output logic                                      SC_USEQ_Done_Out
);

  // Field offsets for the configured widths
  localparam int DEC   = DATAWIDTH_DECODER_SELECTION;
  localparam int MUX   = DATAWIDTH_MUX_SELECTION;
  localparam int ALU   = DATAWIDTH_ALU_SELECTION;
  localparam int SHIFT = DATAWIDTH_REGSHIFTER_SELECTION;

  localparam int TGT_LSB    = 0;
  localparam int NEXT_LSB   = TGT_LSB + UPC_WIDTH;
  localparam int SHSEL_LSB  = NEXT_LSB + NEXT_W;
  localparam int SHLOAD_BIT = SHSEL_LSB + SHIFT;
  localparam int ALU_LSB    = SHLOAD_BIT + 1;
  localparam int MUXB_LSB   = ALU_LSB + ALU;
  localparam int MUXA_LSB   = MUXB_LSB + MUX;
  localparam int DEC_LSB    = MUXA_LSB + MUX;

  seqState_t                  state;
  logic [UPC_WIDTH-1:0]       upc;
  logic [LOOPCNT_WIDTH-1:0]   cnt;
  logic [UWORD_WIDTH-1:0]     word;

  nextOp_t                    nxtOp;
  logic [UPC_WIDTH-1:0]       tgt;
  logic [UPC_WIDTH-1:0]       upcNext;
  logic [LOOPCNT_WIDTH-1:0]   cntNext;
  logic                       isHalt;
  logic                       storeWr;

  // No branch opcode tests overflow; the pin is kept for datapath compatibility
  logic unusedOverflow;
  assign unusedOverflow = SC_USEQ_Overflow_InLow;

  // Writes are only accepted outside RUN, so the fetched word never changes under us
  assign storeWr = SC_USEQ_ProgWrite_In && (state != ST_RUN);

  sc_useq_store #(
    .ADDR_W (UPC_WIDTH),
    .DATA_W (UWORD_WIDTH)
  ) uStore (
    .clk    (SC_USEQ_CLOCK_50),
    .rstN   (SC_USEQ_Reset_InLow),
    .wrEn   (storeWr),
    .wrAddr (SC_USEQ_ProgAddr_In),
    .wrData (SC_USEQ_ProgData_In),
    .rdAddr (upc),
    .rdData (word)
  );

`ifdef SC_USEQ_WATCHDOG_EN
  logic [7:0] wdCnt;
  logic       timeoutQ;
  assign SC_USEQ_Timeout_Out = timeoutQ;
`endif

  // Next micro-address and loop count from the current word; flags are live
  always_comb begin
    nxtOp   = nextOp_t'(word[NEXT_LSB +: NEXT_W]);
    tgt     = word[TGT_LSB +: UPC_WIDTH];
    upcNext = upc + UPC_WIDTH'(1);
    cntNext = cnt;
    isHalt  = 1'b0;
    case (nxtOp)
      NX_SEQ:  ;
      NX_JMP:  upcNext = tgt;
      NX_BRZ:  if (!SC_USEQ_Zero_InLow)     upcNext = tgt;
      NX_BRN:  if (!SC_USEQ_Negative_InLow) upcNext = tgt;
      NX_BRC:  if (!SC_USEQ_Carry_InLow)    upcNext = tgt;
      NX_LOOP: begin
        if (cnt != '0) begin
          cntNext = cnt - LOOPCNT_WIDTH'(1);
          upcNext = tgt;
        end
      end
      default: isHalt = 1'b1;
    endcase
  end

  // Sequencer FSM: IDLE -> RUN on start, RUN -> DONE on halt, DONE -> IDLE
  always_ff @(posedge SC_USEQ_CLOCK_50 or negedge SC_USEQ_Reset_InLow) begin
    if (!SC_USEQ_Reset_InLow) begin
      state <= ST_IDLE;
      upc   <= '0;
      cnt   <= '0;
`ifdef SC_USEQ_WATCHDOG_EN
      wdCnt    <= '0;
      timeoutQ <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (SC_USEQ_Start_In) begin
            upc   <= SC_USEQ_StartAddr_In;
            cnt   <= SC_USEQ_LoopCount_In;
            state <= ST_RUN;
`ifdef SC_USEQ_WATCHDOG_EN
            wdCnt <= '0;
`endif
          end
        end
        ST_RUN: begin
`ifdef SC_USEQ_WATCHDOG_EN
          wdCnt <= wdCnt + 8'd1;
          // Counter is about to reach 255: abort regardless of the word
          if (wdCnt == 8'd254) begin
            state    <= ST_DONE;
            timeoutQ <= 1'b1;
          end else
`endif
          if (isHalt) begin
            state <= ST_DONE;
          end else begin
            upc <= upcNext;
            cnt <= cntNext;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
`ifdef SC_USEQ_WATCHDOG_EN
          timeoutQ <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Control outputs follow the fetched word in RUN, NOP otherwise
  always_comb begin
    SC_USEQ_DecoderSelectionWrite_Out       = '0;
    SC_USEQ_MUXSelectionBUSA_Out            = '0;
    SC_USEQ_MUXSelectionBUSB_Out            = '0;
    SC_USEQ_ALUSelection_Out                = '0;
    SC_USEQ_RegSHIFTERLoad_OutLow           = NOP_SHLOAD_N;
    SC_USEQ_RegSHIFTERShiftSelection_OutLow = '0;
    if (state == ST_RUN) begin
      SC_USEQ_DecoderSelectionWrite_Out       = word[DEC_LSB +: DEC];
      SC_USEQ_MUXSelectionBUSA_Out            = word[MUXA_LSB +: MUX];
      SC_USEQ_MUXSelectionBUSB_Out            = word[MUXB_LSB +: MUX];
      SC_USEQ_ALUSelection_Out                = word[ALU_LSB +: ALU];
      SC_USEQ_RegSHIFTERLoad_OutLow           = word[SHLOAD_BIT];
      SC_USEQ_RegSHIFTERShiftSelection_OutLow = word[SHSEL_LSB +: SHIFT];
    end
  end

  assign SC_USEQ_Busy_Out = (state == ST_RUN);
  assign SC_USEQ_Done_Out = (state == ST_DONE);

endmodule

// File: tb/tb_sc_useq_controller.sv
// Randomized self-checking bench for sc_useq_controller with a lock-step
// behavioural model (program array, integer micro-PC and loop count).
module tb_sc_useq_controller;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        startIn = 1'b0;
  logic [3:0]  startAddr = '0;
  logic [4:0]  loopCount = '0;
  logic        progWrite = 1'b0;
  logic [3:0]  progAddr = '0;
  logic [28:0] progData = '0;
  logic        ovfN = 1'b1, carryN = 1'b1, negN = 1'b1, zeroN = 1'b1;
  logic [2:0]  decOut;
  logic [5:0]  muxAOut, muxBOut;
  logic [3:0]  aluOut;
  logic        shLoadN;
  logic [1:0]  shSel;
  logic        busy, done;
`ifdef SC_USEQ_WATCHDOG_EN
  logic        timeoutOut;
`endif

  int vecs = 0;
  int errs = 0;

  // Model state
  logic [28:0] mdl [16];
  int mpc, mcnt;

  localparam logic [31:0] NOP_CTRL = 32'h4;

  sc_useq_controller dut (
    .SC_USEQ_CLOCK_50                        (clk),
    .SC_USEQ_Reset_InLow                     (rstN),
    .SC_USEQ_Start_In                        (startIn),
    .SC_USEQ_StartAddr_In                    (startAddr),
    .SC_USEQ_LoopCount_In                    (loopCount),
    .SC_USEQ_ProgWrite_In                    (progWrite),
    .SC_USEQ_ProgAddr_In                     (progAddr),
    .SC_USEQ_ProgData_In                     (progData),
    .SC_USEQ_Overflow_InLow                  (ovfN),
    .SC_USEQ_Carry_InLow                     (carryN),
    .SC_USEQ_Negative_InLow                  (negN),
    .SC_USEQ_Zero_InLow                      (zeroN),
    .SC_USEQ_DecoderSelectionWrite_Out       (decOut),
    .SC_USEQ_MUXSelectionBUSA_Out            (muxAOut),
    .SC_USEQ_MUXSelectionBUSB_Out            (muxBOut),
    .SC_USEQ_ALUSelection_Out                (aluOut),
    .SC_USEQ_RegSHIFTERLoad_OutLow           (shLoadN),
    .SC_USEQ_RegSHIFTERShiftSelection_OutLow (shSel),
`ifdef SC_USEQ_WATCHDOG_EN
    .SC_USEQ_Timeout_Out                     (timeoutOut),
`endif
    .SC_USEQ_Busy_Out                        (busy),
    .SC_USEQ_Done_Out                        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctrlVec();
    return 32'({decOut, muxAOut, muxBOut, aluOut, shLoadN, shSel});
  endfunction

  function automatic logic [28:0] mkWord(input int dec, input int ma, input int mb, input int alu,
                                         input int shl, input int shs, input int nxt, input int tgt);
    logic [31:0] d, a, b, u, l, s, n, t;
    d = dec; a = ma; b = mb; u = alu; l = shl; s = shs; n = nxt; t = tgt;
    return {d[2:0], a[5:0], b[5:0], u[3:0], l[0], s[1:0], n[2:0], t[3:0]};
  endfunction

  function automatic logic [28:0] randWord();
    return 29'($urandom);
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 16; i++) mdl[i] = '0;
  endtask

  task automatic idleInputs();
    startIn = 1'b0;
    progWrite = 1'b0;
  endtask

  // Asynchronous reset from mid-cycle; outputs must drop at once
  task automatic applyReset();
    idleInputs();
    rstN = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ctrl", ctrlVec(), NOP_CTRL);
`ifdef SC_USEQ_WATCHDOG_EN
    chk("rst_timeout", 32'(timeoutOut), 32'd0);
`endif
    clearModel();
    @(posedge clk); #1;
    rstN = 1'b1;
  endtask

  task automatic progWord(input int a, input logic [28:0] w);
    progWrite = 1'b1;
    progAddr = a[3:0];
    progData = w;
    @(posedge clk); #1;
    progWrite = 1'b0;
    mdl[a] = w;
  endtask

  // Runs one routine in lock-step with the model. flagForce < 0 randomizes flags
  // each cycle; otherwise its low nibble is {ovf,carry,neg,zero} (active low).
  task automatic runRoutine(input int sa, input int lc, input int maxCyc, input int flagForce,
                            input bit noise, input int abortAt, output int runLen);
    logic [28:0] w;
    logic [31:0] ff;
    logic [3:0]  fl;
    int op, tgt, a;
    bit halted, timedOut;
    logic [28:0] d;
    startIn = 1'b1;
    startAddr = sa[3:0];
    loopCount = lc[4:0];
    if (noise && $urandom_range(0, 1) == 1) begin
      a = $urandom_range(0, 15);
      d = randWord();
      progWrite = 1'b1; progAddr = a[3:0]; progData = d;
      mdl[a] = d;
    end
    @(posedge clk); #1;
    idleInputs();
    mpc = sa; mcnt = lc; runLen = 0; halted = 0; timedOut = 0;
    while (!halted && !timedOut && runLen < maxCyc) begin
      w = mdl[mpc];
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      chk("run_ctrl", ctrlVec(), 32'(w[28:7]));
      runLen++;
      if (runLen == abortAt) begin
        applyReset();
        return;
      end
      ff = (flagForce < 0) ? $urandom : flagForce;
      fl = ff[3:0];
      {ovfN, carryN, negN, zeroN} = fl;
      if (noise) begin
        startIn = 1'($urandom_range(0, 1));
        startAddr = 4'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          progWrite = 1'b1; progAddr = 4'($urandom); progData = randWord();
        end
      end
      op = int'(w[6:4]);
      tgt = int'(w[3:0]);
      case (op)
        0: mpc = (mpc + 1) % 16;
        1: mpc = tgt;
        2: mpc = (fl[0] == 1'b0) ? tgt : (mpc + 1) % 16;
        3: mpc = (fl[1] == 1'b0) ? tgt : (mpc + 1) % 16;
        4: mpc = (fl[2] == 1'b0) ? tgt : (mpc + 1) % 16;
        5: if (mcnt > 0) begin mcnt--; mpc = tgt; end else mpc = (mpc + 1) % 16;
        default: halted = 1;
      endcase
`ifdef SC_USEQ_WATCHDOG_EN
      if (runLen == 255) timedOut = 1;
`endif
      @(posedge clk); #1;
      idleInputs();
    end
    if (!halted && !timedOut) begin
      // Program never finished within the budget: recover through reset
      applyReset();
      return;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_ctrl", ctrlVec(), NOP_CTRL);
`ifdef SC_USEQ_WATCHDOG_EN
    chk("done_timeout", 32'(timeoutOut), 32'(timedOut));
`endif
    if (noise) begin
      startIn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 15);
        d = randWord();
        progWrite = 1'b1; progAddr = a[3:0]; progData = d;
        mdl[a] = d;
      end
    end
    @(posedge clk); #1;
    idleInputs();
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_ctrl", ctrlVec(), NOP_CTRL);
`ifdef SC_USEQ_WATCHDOG_EN
    chk("post_timeout", 32'(timeoutOut), 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int len, n, a;
    clearModel();
    // Reset state
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ctrl", ctrlVec(), NOP_CTRL);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // SEQ, SEQ, HALT with dec 1,2,3
    progWord(0, mkWord(1, 5, 6, 7, 1, 1, 0, 0));
    progWord(1, mkWord(2, 8, 9, 10, 0, 2, 0, 0));
    progWord(2, mkWord(3, 11, 12, 13, 1, 3, 6, 0));
    runRoutine(0, 0, 20, -1, 0, 0, len);
    chk("seq_len", 32'(len), 32'd3);

    // LOOP to self with count 3, then HALT
    progWord(0, mkWord(1, 0, 0, 1, 1, 0, 5, 0));
    progWord(1, mkWord(2, 0, 0, 2, 1, 0, 6, 0));
    runRoutine(0, 3, 20, -1, 0, 0, len);
    chk("loop_len", 32'(len), 32'd5);

    // BRZ to 5, taken and not taken
    progWord(0, mkWord(1, 0, 0, 3, 1, 0, 2, 5));
    progWord(1, mkWord(2, 0, 0, 0, 1, 0, 6, 0));
    progWord(5, mkWord(5, 0, 0, 0, 1, 0, 6, 0));
    runRoutine(0, 0, 20, 14, 0, 0, len);
    chk("brz_taken_len", 32'(len), 32'd2);
    runRoutine(0, 0, 20, 15, 0, 0, len);
    chk("brz_fall_len", 32'(len), 32'd2);

    // Wrap from 15 to 0
    progWord(15, mkWord(7, 1, 1, 1, 0, 0, 0, 0));
    progWord(0, mkWord(6, 0, 0, 0, 1, 0, 6, 0));
    runRoutine(15, 0, 20, -1, 0, 0, len);
    chk("wrap_len", 32'(len), 32'd2);

    // Noise during RUN, then reset mid-routine; store must read back zero
    progWord(0, mkWord(4, 2, 3, 4, 1, 0, 1, 0));
    runRoutine(0, 0, 20, -1, 1, 4, len);
    chk("abort_len", 32'(len), 32'd4);
    runRoutine(0, 0, 5, -1, 0, 0, len);

    // Randomized programs
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        a = $urandom_range(0, 15);
        progWord(a, randWord());
      end
      runRoutine($urandom_range(0, 15), $urandom_range(0, 31), 40, -1,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0, len);
    end

`ifdef SC_USEQ_WATCHDOG_EN
    // JMP to self with no HALT: watchdog aborts after 255 RUN cycles
    progWord(0, mkWord(4, 0, 0, 0, 1, 0, 1, 0));
    runRoutine(0, 0, 300, -1, 0, 0, len);
    chk("wd_len", 32'(len), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
